pipe_hazard_ctrl: RTL

Pipeline control unit for the 5-stage RISC-V core. It sequences the IF/ID and ID/EX pipeline registers and the PC: write enables for stalls, synchronous clears for bubbles and flushes. It resolves load-use hazards, taken-branch redirects, instruction-memory wait states, multi-cycle mul/div occupancy of EX, and a drain-then-halt sequence for ECALL/EBREAK. It sits beside the datapath: inputs come from the ID/EX/MEM stage registers, outputs drive the `write` and clear inputs of the IF/ID and ID/EX registers and the PC enable.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 24 ++
 rtl/load_use_detect.sv | 25 ++
 rtl/pipe_hazard_ctrl.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  // Controller FSM states
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_BUSY = 2'd1,
    DRAIN   = 2'd2,
    HALTED  = 2'd3
  } ctrl_state_t;

  // x0 is hard-wired zero, so a "write" to it can never create a hazard
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Default total EX occupancy of a mul/div op, start cycle included
  localparam int MD_LAT_DEFAULT = 4;

  // Default number of cycles spent retiring in-flight work before halting
  localparam int DRAIN_CYC_DEFAULT = 3;

  // Width of the shared state down-counter
  localparam int CNT_W = 3;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: flags a load in EX whose destination is read by the
// instruction currently in ID. Purely combinational.
import pipe_ctrl_pkg::*;

module load_use_detect (
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  output logic       hazard
);

  logic rs1_match;
  logic rs2_match;

  // Only sources the ID instruction really reads can create a dependency
  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  // A load targeting x0 never produces a value anyone waits for
  assign hazard = ex_mem_read && (ex_rd != REG_ZERO) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencing for the IF/ID and ID/EX registers
// and the PC of the 5-stage core. Handles taken-branch squash, multi-cycle
// mul/div occupancy, load-use bubbles, fetch wait states and ECALL/EBREAK
// drain-then-halt.
// Optional feature macro: HAZ_PERF_EN builds the stall/flush perf counters;
// without it both counter ports read as zero and no counter flops exist.
import pipe_ctrl_pkg::*;

module pipe_hazard_ctrl #(
  parameter int MD_LAT    = MD_LAT_DEFAULT,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        id_halt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_md_start,
  input  logic        ex_branch_taken,
  input  logic        imem_ready,
  input  logic        resume,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_write,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic        halted,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  // Counter reload values: the entry cycle is spent in RUN, the remaining
  // cycles count down to zero inside the busy/drain state.
  localparam logic [CNT_W-1:0] MD_LOAD    = CNT_W'(MD_LAT - 2);
  localparam logic [CNT_W-1:0] DRAIN_LOAD = CNT_W'(DRAIN_CYC - 1);

  ctrl_state_t      state_reg;
  ctrl_state_t      state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             hazard;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rd       (ex_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .hazard      (hazard)
  );

  // State and countdown registers; reset drops straight back to RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Control outputs and next state, combinational from state plus inputs
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_write  = 1'b1;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    halted       = 1'b0;
    state_next   = state_reg;
    cnt_next     = cnt_reg;

    case (state_reg)
      RUN: begin
        if (ex_branch_taken) begin
          // Squash the two younger instructions in IF/ID and ID/EX; the PC
          // loads the branch target.
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
        end else if (ex_md_start) begin
          // Freeze the front end and keep EX/MEM empty while mul/div works
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_write  = 1'b0;
          ex_mem_flush = 1'b1;
          state_next   = MD_BUSY;
          cnt_next     = MD_LOAD;
        end else if (hazard) begin
          // Hold PC and IF/ID for one cycle, insert a bubble into ID/EX
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end else if (!imem_ready) begin
          // Fetch not back yet: hold PC, feed a bubble into ID
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
        end else if (id_halt) begin
          // Let the halt instruction move to EX, stop fetching behind it
          pc_write    = 1'b0;
          if_id_flush = 1'b1;
          state_next  = DRAIN;
          cnt_next    = DRAIN_LOAD;
        end
      end

      MD_BUSY: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_write  = 1'b0;
        ex_mem_flush = 1'b1;
        if (cnt_reg == '0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      DRAIN: begin
        pc_write    = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (cnt_reg == '0) begin
          state_next = HALTED;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end

      HALTED: begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        id_ex_write = 1'b0;
        halted      = 1'b1;
        if (resume) begin
          state_next = RUN;
        end
      end

      default: begin
        state_next = RUN;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;
  logic        stall_inc;
  logic        flush_inc;

  // A halted core is idle, not stalled; branches only flush while in RUN
  assign stall_inc = !pc_write && (state_reg != HALTED);
  assign flush_inc = (state_reg == RUN) && ex_branch_taken;

  // Free-running perf counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles_reg <= '0;
      flush_count_reg  <= '0;
    end else begin
      if (stall_inc) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (flush_inc) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif

endmodule
